sys_psum_deskew: RTL and testbench

//   Output-side collector for the weight-stationary systolic array. Takes the

---
 rtl/sys_psum_deskew_if.sv | 24 ++
 rtl/sys_psum_deskew.sv | 105 ++++++++++
 tb/tb_sys_psum_deskew.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_psum_deskew_if.sv
// Row-stream bundle between the systolic array bottom edge, the deskew
// collector and the downstream row consumer.
interface sys_psum_deskew_if #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16
);
   localparam int PSUM_WIDTH = 2 * DATA_WIDTH;

   logic [SYS_COL-1:0]                  en_in;
   logic [0:SYS_COL-1][PSUM_WIDTH-1:0]  psum_in;
   logic                                out_valid;
   logic                                out_ready;
   logic [0:SYS_COL-1][PSUM_WIDTH-1:0]  out_data;

   modport master (
      output en_in, psum_in, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  en_in, psum_in, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/sys_psum_deskew.sv
// Output-side collector for the weight-stationary systolic array: realigns
// the skewed per-column psum streams into whole rows, buffers them in a
// small first-word-fall-through FIFO and hands them out on valid/ready.
// The array never stalls, so a row arriving on a full FIFO is dropped.
module sys_psum_deskew #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   sys_psum_deskew_if.slave            bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        skew_err,
   input  logic                        clr_flags
);
   localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;

   typedef logic [0:SYS_COL-1][PSUM_WIDTH-1:0] row_t;

   logic [SYS_COL-1:0] al_v;
   row_t               al_d;

   // Column j is delayed SYS_COL-1-j cycles so all columns of a row meet
   // in the same cycle as the last column.
   for (genvar j = 0; j < SYS_COL; j++) begin : g_col
      localparam int D = SYS_COL - 1 - j;
      if (D == 0) begin : g_pass
         assign al_v[j] = bus.en_in[j];
         assign al_d[j] = bus.psum_in[j];
      end else begin : g_dly
         logic [D-1:0]                  v_q;
         logic [D:0]                    v_chain;
         logic [D-1:0][PSUM_WIDTH-1:0]  d_q;
         logic [D:0][PSUM_WIDTH-1:0]    d_chain;

         // Chain vectors carry the live input in slot 0 so one shift
         // expression covers every delay length from 1 upward.
         assign v_chain = {v_q, bus.en_in[j]};
         assign d_chain = {d_q, bus.psum_in[j]};

         // Valid delay line, cleared by reset so no stale row survives.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) v_q <= '0;
            else       v_q <= v_chain[D-1:0];
         end

         // Data delay line follows valid; contents are don't-care when invalid.
         always_ff @(posedge clk) begin
            d_q <= d_chain[D-1:0];
         end

         assign al_v[j] = v_q[D-1];
         assign al_d[j] = d_q[D-1];
      end
   end

   row_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             all_v;
   logic             any_v;
   logic             pop;
   logic             push;
   logic             drop;
   logic             partial;

   assign all_v   = &al_v;
   assign any_v   = |al_v;
   assign pop     = bus.out_valid & bus.out_ready;
   // A full FIFO still accepts a row when the head leaves in the same cycle.
   assign push    = all_v & ((count < CNT_W'(FIFO_DEPTH)) | pop);
   assign drop    = all_v & ~push;
   assign partial = any_v & ~all_v;

   // FIFO bookkeeping and sticky error flags; a new event beats a clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         skew_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count + CNT_W'(push) - CNT_W'(pop);
         overflow <= drop    | (overflow & ~clr_flags);
         skew_err <= partial | (skew_err & ~clr_flags);
      end
   end

   // Row storage; when full with a pop, the write reuses the slot being read out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= al_d;
   end

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign fifo_count    = count;
endmodule

// File: tb/tb_sys_psum_deskew.sv
// Scoreboard bench for sys_psum_deskew: a cycle schedule of skewed rows is
// played into the DUT; a row-level model predicts FIFO contents and flags,
// and a separate monitor compares DUT outputs against the predictions.
module tb_sys_psum_deskew;
   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int PW    = 2 * DW;
   localparam int NCYC  = 900;

   typedef logic [0:N-1][PW-1:0] row_t;
   typedef struct {
      int occ;
      bit ovf;
      bit skw;
   } stat_t;

   logic                      clk = 1'b0;
   logic                      rstn = 1'b0;
   logic                      clr_flags = 1'b0;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic                      overflow;
   logic                      skew_err;

   sys_psum_deskew_if #(.SYS_COL(N), .DATA_WIDTH(DW)) bus ();

   sys_psum_deskew #(.SYS_COL(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .skew_err   (skew_err),
      .clr_flags  (clr_flags)
   );

   always #5 clk = ~clk;

   logic          s_en  [NCYC][N];
   logic [PW-1:0] s_d   [NCYC][N];
   bit            s_rdy [NCYC];
   bit            s_clr [NCYC];
   bit            s_rst [NCYC];

   stat_t stq[$];
   row_t  sb[$];
   int    vectors = 0;
   int    miscompares = 0;

   task automatic chk(input string nm, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // A row started at cycle s presents column j at cycle s+j; miss disables one column.
   task automatic add_row(input int s, input int miss, input int base);
      for (int j = 0; j < N; j++) begin
         s_en[s+j][j] = (j != miss);
         s_d[s+j][j]  = PW'(base + j);
      end
   endtask

   // Monitor: checks status every cycle and consumes scoreboard rows on handshakes.
   initial begin
      stat_t st;
      forever begin
         @(negedge clk);
         #4;
         if (stq.size() != 0) begin
            st = stq.pop_front();
            chk("out_valid",  bus.out_valid, st.occ != 0);
            chk("fifo_count", fifo_count, st.occ);
            chk("overflow",   overflow, st.ovf);
            chk("skew_err",   skew_err, st.skw);
            if (bus.out_valid) begin
               chk("row_expected", sb.size() != 0, 1'b1);
               if (sb.size() != 0) begin
                  chk("out_data", bus.out_data, sb[0]);
                  if (bus.out_ready) void'(sb.pop_front());
               end
            end else begin
               chk("idle_data", bus.out_data, '0);
            end
         end
      end
   end

   // Driver plus row-level reference model.
   initial begin
      int   hist_start;
      int   k;
      row_t mq[$];
      row_t row;
      bit   ovf, skw, all_v, any_v, v, pop, drop;
      int   miss;

      hist_start = 0;
      ovf = 0;
      skw = 0;
      bus.en_in     = '0;
      bus.psum_in   = '0;
      bus.out_ready = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         for (int j = 0; j < N; j++) begin
            s_en[c][j] = 1'b0;
            s_d[c][j]  = $urandom;
         end
         s_rdy[c] = 1;
         s_clr[c] = 0;
         s_rst[c] = 0;
      end

      // Directed scenarios.
      for (int c = 0; c < 3; c++) s_rst[c] = 1;
      add_row(10, -1, 100);
      for (int r = 0; r < 4; r++) add_row(30 + r, -1, 10 * r);
      for (int c = 50; c < 80; c++) s_rdy[c] = 0;
      for (int r = 0; r < 5; r++) add_row(52 + r, -1, 200 + 10 * r);
      s_clr[90] = 1;
      for (int c = 95; c < 120; c++) s_rdy[c] = (c == 113);
      for (int r = 0; r < 4; r++) add_row(96 + r, -1, 300 + 10 * r);
      add_row(110, -1, 400);
      add_row(130, 2, 500);
      s_clr[140] = 1;
      for (int c = 145; c < 166; c++) s_rdy[c] = 0;
      add_row(150, -1, 600);
      add_row(153, -1, 610);
      add_row(154, -1, 620);
      s_rst[155] = 1;
      for (int c = 155; c <= 160; c++)
         for (int j = 0; j < N; j++) s_en[c][j] = 1'b0;
      add_row(167, 0, 700);
      s_clr[170] = 1;
      s_clr[175] = 1;

      // Randomized traffic.
      for (int c = 180; c < NCYC - 40; c++) begin
         s_rdy[c] = ($urandom_range(0, 9) < 7);
         s_clr[c] = ($urandom_range(0, 39) == 0);
         s_rst[c] = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 9) < 5) begin
            miss = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            add_row(c, miss, int'($urandom));
         end
      end

      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         rstn = !s_rst[c];
         for (int j = 0; j < N; j++) begin
            bus.en_in[j]   = s_en[c][j];
            bus.psum_in[j] = s_d[c][j];
         end
         bus.out_ready = s_rdy[c];
         clr_flags     = s_clr[c];

         if (s_rst[c]) begin
            mq.delete();
            sb.delete();
            ovf = 0;
            skw = 0;
            hist_start = c + 1;
            stq.push_back('{0, 0, 0});
         end else begin
            stq.push_back('{mq.size(), ovf, skw});
            all_v = 1;
            any_v = 0;
            for (int j = 0; j < N; j++) begin
               k = c - (N - 1 - j);
               v = (k >= hist_start) && s_en[k][j];
               row[j] = (k >= 0) ? s_d[k][j] : '0;
               all_v &= v;
               any_v |= v;
            end
            pop = (mq.size() != 0) && s_rdy[c];
            if (pop) void'(mq.pop_front());
            drop = 0;
            if (all_v) begin
               if (mq.size() < DEPTH) begin
                  mq.push_back(row);
                  sb.push_back(row);
               end else begin
                  drop = 1;
               end
            end
            ovf = drop | (ovf & !s_clr[c]);
            skw = (any_v && !all_v) | (skw & !s_clr[c]);
         end
      end

      @(negedge clk);
      #6;
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
